// File: rtl/hardware_stack_unit_if.sv
// Stack unit port bundle: control-side requests in, register-file write and status out.
// slave is the stack unit's view, master is the driver's view.
interface hardware_stack_unit_if #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned STACK_ADDR_WIDTH = 4
);
  logic                        push;
  logic                        pop;
  logic [DATA_WIDTH-1:0]       push_data;
  logic                        stack_clear_errors;
  logic                        stack_write_enable;
  logic [DATA_WIDTH-1:0]       stack_register_write_data;
  logic [STACK_ADDR_WIDTH:0]   stack_count;
  logic                        stack_full;
  logic                        stack_empty;
  logic                        stack_overflow;
  logic                        stack_underflow;

  modport slave (
    input  push, pop, push_data, stack_clear_errors,
    output stack_write_enable, stack_register_write_data, stack_count,
           stack_full, stack_empty, stack_overflow, stack_underflow
  );

  modport master (
    output push, pop, push_data, stack_clear_errors,
    input  stack_write_enable, stack_register_write_data, stack_count,
           stack_full, stack_empty, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/hardware_stack_unit.sv
// LIFO stack feeding register 0 of the register file. A pop produces a one-cycle write
// strobe with the popped value in the following cycle.
// Optional feature macro: STACK_ERROR_FLAGS_EN enables sticky overflow/underflow flags.
module hardware_stack_unit #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned STACK_ADDR_WIDTH = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  hardware_stack_unit_if.slave  bus
);

  localparam int unsigned Depth = 2 ** STACK_ADDR_WIDTH;
  localparam int unsigned CntW  = STACK_ADDR_WIDTH + 1;

  typedef logic [CntW-1:0] count_t;

  logic [DATA_WIDTH-1:0]       mem [Depth];
  count_t                      count_q, count_d;
  count_t                      count_m1;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic                        we_q, we_d;
  logic                        full, empty;
  logic                        do_push, do_pop, do_swap, do_bypass;
  logic                        mem_we;
  logic [STACK_ADDR_WIDTH-1:0] mem_idx;
  logic [STACK_ADDR_WIDTH-1:0] wr_idx, top_idx;

  assign full     = (count_q == count_t'(Depth));
  assign empty    = (count_q == '0);
  assign count_m1 = count_q - count_t'(1);
  // count is the write index; at Depth the low bits wrap but a push is rejected then
  assign wr_idx   = count_q[STACK_ADDR_WIDTH-1:0];
  assign top_idx  = count_m1[STACK_ADDR_WIDTH-1:0];

  assign do_push   = bus.push & ~bus.pop & ~full;
  assign do_pop    = bus.pop & ~bus.push & ~empty;
  assign do_swap   = bus.push & bus.pop & ~empty;
  assign do_bypass = bus.push & bus.pop & empty;

  // Next-state: count, strobe, popped data and memory write port
  always_comb begin
    count_d = count_q;
    data_d  = data_q;
    we_d    = 1'b0;
    mem_we  = 1'b0;
    mem_idx = wr_idx;
    if (do_push) begin
      count_d = count_q + count_t'(1);
      mem_we  = 1'b1;
      mem_idx = wr_idx;
    end else if (do_pop) begin
      count_d = count_m1;
      data_d  = mem[top_idx];
      we_d    = 1'b1;
    end else if (do_swap) begin
      // Replace the top in place: old top goes out, new value takes its slot
      data_d  = mem[top_idx];
      we_d    = 1'b1;
      mem_we  = 1'b1;
      mem_idx = top_idx;
    end else if (do_bypass) begin
      data_d  = bus.push_data;
      we_d    = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  // Stack memory, deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= bus.push_data;
    end
  end

  assign bus.stack_write_enable        = we_q;
  assign bus.stack_register_write_data = data_q;
  assign bus.stack_count               = count_q;
  assign bus.stack_full                = full;
  assign bus.stack_empty               = empty;

`ifdef STACK_ERROR_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // Sticky flags; a new error in the clear cycle wins over the clear
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.stack_clear_errors) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (bus.push && !bus.pop && full) begin
      ovf_d = 1'b1;
    end
    if (bus.pop && !bus.push && empty) begin
      unf_d = 1'b1;
    end
  end

  // Flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
`else
  logic unused_clear_errors;
  assign unused_clear_errors = bus.stack_clear_errors;
  assign bus.stack_overflow  = 1'b0;
  assign bus.stack_underflow = 1'b0;
`endif

endmodule
